// File: rtl/serial_regbank.sv
// Byte-serial command front end to a bank of WIDTH-bit output ports and input ports.
// Optional macro SERREG_ECHO_EN: transmit an acknowledge byte after every write.
module serial_regbank #(
  parameter int WIDTH   = 32,
  parameter int NOUT    = 16,
  parameter int NIN     = 8,
  parameter int TIMEOUT = 2000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [7:0]              datain,
  input  logic                    ready,
  output logic                    enout,
  output logic [7:0]              dataout,
  input  logic [NIN*WIDTH-1:0]    in_flat,
  output logic [NOUT*WIDTH-1:0]   out_flat
);

  localparam int NB = WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef SERREG_ECHO_EN
  typedef enum logic [1:0] {IDLE, WDATA, RSEND, ACK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WDATA, RSEND} state_t;
`endif

  state_t           state_reg;
  logic [3:0]       idx_reg;
  logic [2:0]       cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [TW-1:0]    timer_reg;
  logic [1:0]       holdoff_reg;
  logic             snap_reg;
  logic [7:0]       dataout_reg;

  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] shift_up;
  logic [WIDTH-1:0] in_sel;
  logic             wr_commit;
  logic             tx_ok;

  assign wr_word   = WIDTH'({shift_reg, datain});
  assign shift_up  = shift_reg << 8;
  assign wr_commit = (state_reg == WDATA) && load && (cnt_reg == 3'(NB - 1));

  always_comb begin
    in_sel = '0;
    for (int k = 0; k < NIN; k++)
      if (idx_reg == 4'(k)) in_sel = in_flat[k*WIDTH +: WIDTH];
  end

  // The handshake is qualified by the live ready so a pulse never lands in a ready=0 cycle.
  always_comb begin
    tx_ok = (state_reg == RSEND) && !snap_reg && (holdoff_reg == 2'd0);
`ifdef SERREG_ECHO_EN
    if ((state_reg == ACK) && (holdoff_reg == 2'd0)) tx_ok = 1'b1;
`endif
  end

  assign enout   = tx_ok && ready;
  assign dataout = dataout_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      timer_reg   <= '0;
      holdoff_reg <= '0;
      snap_reg    <= 1'b0;
      dataout_reg <= '0;
    end else begin
      if (holdoff_reg != 2'd0) holdoff_reg <= holdoff_reg - 2'd1;
      case (state_reg)
        IDLE: begin
          if (load && (datain[6:4] == 3'b000)) begin
            idx_reg   <= datain[3:0];
            cnt_reg   <= '0;
            timer_reg <= '0;
            if (datain[7]) begin
              state_reg <= WDATA;
            end else begin
              state_reg <= RSEND;
              snap_reg  <= 1'b1;
            end
          end
        end
        WDATA: begin
          if (load) begin
            shift_reg <= wr_word;
            timer_reg <= '0;
            cnt_reg   <= cnt_reg + 3'd1;
            if (wr_commit) begin
`ifdef SERREG_ECHO_EN
              state_reg   <= ACK;
              dataout_reg <= {1'b1, 3'b000, idx_reg};
`else
              state_reg   <= IDLE;
`endif
            end
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        RSEND: begin
          if (snap_reg) begin
            snap_reg    <= 1'b0;
            shift_reg   <= in_sel;
            dataout_reg <= in_sel[WIDTH-1 -: 8];
          end else if (enout) begin
            shift_reg   <= shift_up;
            dataout_reg <= shift_up[WIDTH-1 -: 8];
            holdoff_reg <= 2'd2;
            cnt_reg     <= cnt_reg + 3'd1;
            if (cnt_reg == 3'(NB - 1)) state_reg <= IDLE;
          end
        end
`ifdef SERREG_ECHO_EN
        ACK: begin
          if (enout) begin
            holdoff_reg <= 2'd2;
            state_reg   <= IDLE;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One register per output port; the last port drops back to zero after one clock.
  genvar gi;
  generate
    for (gi = 0; gi < NOUT; gi++) begin : g_port
      logic [WIDTH-1:0] port_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          port_reg <= '0;
        else if (wr_commit && (idx_reg == 4'(gi)))
          port_reg <= wr_word;
        else if (gi == NOUT - 1)
          port_reg <= '0;
      end
      assign out_flat[gi*WIDTH +: WIDTH] = port_reg;
    end
  endgenerate

endmodule

// File: tb/tb_serial_regbank.sv
// Self-checking bench for serial_regbank: vector table of port writes/reads plus corner sequences.
module tb_serial_regbank;
  localparam int WIDTH = 32;
  localparam int NOUT  = 16;
  localparam int NIN   = 8;

  logic                  clock  = 1'b0;
  logic                  reset  = 1'b1;
  logic                  load   = 1'b0;
  logic [7:0]            datain = 8'h00;
  logic                  ready  = 1'b1;
  logic                  enout;
  logic [7:0]            dataout;
  logic [NIN*WIDTH-1:0]  in_flat;
  logic [NOUT*WIDTH-1:0] out_flat;

  serial_regbank #(.WIDTH(WIDTH), .NOUT(NOUT), .NIN(NIN), .TIMEOUT(2000)) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .datain  (datain),
    .ready   (ready),
    .enout   (enout),
    .dataout (dataout),
    .in_flat (in_flat),
    .out_flat(out_flat)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [3:0]  idx;
    logic [31:0] data;
  } vec_t;

  vec_t                  vecs[10];
  int                    vectors     = 0;
  int                    miscompares = 0;
  int                    cyc         = 0;
  int                    cmd_cyc     = 0;
  int                    cmd_id      = 0;
  int                    lat_id      = 0;
  int                    last_pulse  = -100;
  logic [7:0]            exp_q[$];
  logic [NOUT*WIDTH-1:0] model = '0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    vectors++;
    if (out_flat !== model) begin
      miscompares++;
      $display("FAIL %s: out_flat got %0h expected %0h", name, out_flat, model);
    end
  endtask

  // Transmit monitor: every enout pulse is matched against the scoreboard queue.
  always @(negedge clock) begin
    if (!reset && enout) begin
      check("enout_with_ready", 64'(ready), 64'd1);
      check("enout_gap_ok", 64'((cyc - last_pulse) >= 3), 64'd1);
      last_pulse = cyc;
      if (lat_id != cmd_id) begin
        check("read_latency_ok", 64'((cyc - cmd_cyc) >= 2), 64'd1);
        lat_id = cmd_id;
      end
      check("enout_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("dataout", 64'(dataout), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load   = 1'b1;
    datain = b;
    tick();
    load   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [31:0] data, input string name);
    send_byte({1'b1, 3'b000, idx});
    send_byte(data[31:24]);
    send_byte(data[23:16]);
    send_byte(data[15:8]);
    check_bank({name, "_before_last"});
`ifdef SERREG_ECHO_EN
    exp_q.push_back({1'b1, 3'b000, idx});
`endif
    send_byte(data[7:0]);
    model[idx*WIDTH +: WIDTH] = data;
    check_bank({name, "_after_last"});
    if (idx == 4'(NOUT - 1)) begin
      tick();
      model[idx*WIDTH +: WIDTH] = '0;
      check_bank({name, "_rtz"});
    end
    drain(name);
  endtask

  task automatic queue_read(input logic [3:0] idx, input logic [31:0] word);
    for (int b = 3; b >= 0; b--) exp_q.push_back(word[b*8 +: 8]);
    cmd_cyc = cyc;
    cmd_id++;
    send_byte({4'b0000, idx});
  endtask

  initial begin
    in_flat = {32'h89ABCDEF, 32'h66666666, 32'h55AA55AA, 32'h44444444,
               32'h33333333, 32'hCAFEF00D, 32'h00000000, 32'h01020304};
    vecs[0] = '{1'b1, 4'd3,  32'h12345678};
    vecs[1] = '{1'b1, 4'd0,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 4'd15, 32'hA5A5A5A5};
    vecs[3] = '{1'b0, 4'd2,  32'hCAFEF00D};
    vecs[4] = '{1'b0, 4'd7,  32'h89ABCDEF};
    vecs[5] = '{1'b0, 4'd9,  32'h00000000};
    vecs[6] = '{1'b1, 4'd14, 32'h0F0F0F0F};
    vecs[7] = '{1'b1, 4'd3,  32'h00000001};
    vecs[8] = '{1'b0, 4'd0,  32'h01020304};
    vecs[9] = '{1'b0, 4'd15, 32'h00000000};

    repeat (3) tick();
    check("reset_enout", 64'(enout), 64'd0);
    check("reset_dataout", 64'(dataout), 64'd0);
    check_bank("reset_ports");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].idx, vecs[i].data, $sformatf("vec%0d_wr", i));
      end else begin
        queue_read(vecs[i].idx, vecs[i].data);
        drain($sformatf("vec%0d_rd", i));
        check_bank($sformatf("vec%0d_rd_ports", i));
      end
    end

    // Reserved bits set: command discarded, next byte is a fresh command.
    send_byte(8'h9F);
    queue_read(4'd2, 32'hCAFEF00D);
    drain("reserved_discard");
    check_bank("reserved_ports");

    // Ready held low: the read must wait, then complete once ready returns.
    ready = 1'b0;
    queue_read(4'd5, 32'h55AA55AA);
    repeat (10) tick();
    check("ready_low_pending", 64'(exp_q.size()), 64'd4);
    ready = 1'b1;
    drain("ready_low");

    // 1999 idle clocks inside a write is still within the timeout.
    send_byte(8'h86);
    send_byte(8'h11);
    repeat (1999) tick();
    send_byte(8'h22);
    send_byte(8'h33);
`ifdef SERREG_ECHO_EN
    exp_q.push_back(8'h86);
`endif
    send_byte(8'h44);
    model[6*WIDTH +: WIDTH] = 32'h11223344;
    check_bank("timeout_edge_write");
    drain("timeout_edge");

    // 2000 idle clocks abort the write; the next byte is a read of port1.
    send_byte(8'h81);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (2000) tick();
    queue_read(4'd1, 32'h00000000);
    drain("timeout_read");
    check_bank("timeout_ports");

    // Reset mid-command clears everything; the following write is parsed normally.
    send_byte(8'h85);
    send_byte(8'hFF);
    reset = 1'b1;
    #1;
    model = '0;
    check("midreset_enout", 64'(enout), 64'd0);
    check("midreset_dataout", 64'(dataout), 64'd0);
    check_bank("midreset_ports");
    tick();
    reset = 1'b0;
    tick();
    check_bank("after_reset_ports");
    do_write(4'd5, 32'h01010101, "post_reset_wr");

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
